// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared types, segment constants and hex-to-segment table for the FND scanner
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } state_t;

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Active-high {g,f,e,d,c,b,a}; polarity is applied at the output register.
  function automatic logic [6:0] seg7_of(input logic [3:0] nib);
    case (nib)
      4'h0: seg7_of = 7'h3F;
      4'h1: seg7_of = 7'h06;
      4'h2: seg7_of = 7'h5B;
      4'h3: seg7_of = 7'h4F;
      4'h4: seg7_of = 7'h66;
      4'h5: seg7_of = 7'h6D;
      4'h6: seg7_of = 7'h7D;
      4'h7: seg7_of = 7'h07;
      4'h8: seg7_of = 7'h7F;
      4'h9: seg7_of = 7'h6F;
      4'hA: seg7_of = 7'h77;
      4'hB: seg7_of = 7'h7C;
      4'hC: seg7_of = 7'h39;
      4'hD: seg7_of = 7'h5E;
      4'hE: seg7_of = 7'h79;
      default: seg7_of = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// rtl/fnd_scan_ctrl_if.sv - display update port: value plus format/dp/blank masks, valid/ready handshake
interface fnd_scan_ctrl_if;
  logic        valid;
  logic        ready;
  logic [15:0] value;
  logic        hex;
  logic [3:0]  dp;
  logic [3:0]  blank;

  modport master (output valid, value, hex, dp, blank, input ready);
  modport slave  (input valid, value, hex, dp, blank, output ready);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble, one bit per cycle, 16 cycles per conversion
module bin2bcd_seq (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [15:0]     bin,
  output logic            done,
  output logic [3:0][3:0] bcd
);

  logic [15:0]     sr;
  logic [3:0]      cnt;
  logic            run;
  logic [3:0][3:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      adj[i] = (bcd[i] >= 4'd5) ? bcd[i] + 4'd3 : bcd[i];
    end
  end

  // done marks the cycle that performs the final shift, so bcd is settled the next cycle.
  assign done = run && (cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= 4'd0;
      sr  <= 16'd0;
      bcd <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= 4'd0;
      sr  <= bin;
      bcd <= '0;
    end else if (run) begin
      {bcd, sr} <= {adj, sr} << 1;
      cnt       <= cnt + 4'd1;
      if (cnt == 4'd15) run <= 1'b0;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - 4-digit multiplexed 7-segment driver with hex/decimal update FSM
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1_000,
  parameter bit COM_ACT_L = 1'b1,
  parameter bit SEG_ACT_L = 1'b1
) (
  input  logic           s00_axi_aclk,
  input  logic           s00_axi_aresetn,
  input  logic           enable,
  fnd_scan_ctrl_if.slave upd,
  output logic           busy,
  output logic           ovf,
  output logic [3:0]     com,
  output logic [6:0]     seg,
  output logic           dp
);

  localparam int         DIV         = CLK_HZ / SCAN_HZ;
  localparam int         CW          = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [3:0] COM_OFF     = COM_ACT_L ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OUT_OFF = SEG_ACT_L ? 7'h7F : 7'h00;
  localparam logic       DP_OFF      = SEG_ACT_L;

  if (DIV < 2) begin : g_div_check
    $error("fnd_scan_ctrl: CLK_HZ/SCAN_HZ must be at least 2");
  end

  state_t          state;
  logic            ready_q;
  logic [15:0]     lat_value;
  logic            lat_hex;
  logic            lat_ovf;
  logic [3:0]      lat_dp;
  logic [3:0]      lat_blank;
  logic [3:0][6:0] sh_seg;
  logic [3:0]      sh_dp;
  logic [3:0]      sh_blank;
  logic [3:0][6:0] commit_seg;
  logic            accept;
  logic            conv_start;
  logic            conv_done;
  logic [3:0][3:0] bcd;

  assign upd.ready  = ready_q;
  assign accept     = upd.valid && ready_q;
  assign conv_start = accept && !upd.hex && (upd.value <= 16'd9999);

  bin2bcd_seq u_bcd (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .start (conv_start),
    .bin   (upd.value),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (lat_hex)      commit_seg[i] = seg7_of(lat_value[4*i +: 4]);
      else if (lat_ovf) commit_seg[i] = SEG_DASH;
      else              commit_seg[i] = seg7_of(bcd[i]);
    end
  end

  // The shadow is written only in COMMIT so a scan never mixes old and new digits.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state     <= ST_IDLE;
      ready_q   <= 1'b1;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      lat_value <= 16'd0;
      lat_hex   <= 1'b0;
      lat_ovf   <= 1'b0;
      lat_dp    <= 4'd0;
      lat_blank <= 4'd0;
      sh_seg    <= {4{seg7_of(4'd0)}};
      sh_dp     <= 4'd0;
      sh_blank  <= 4'hF;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_value <= upd.value;
            lat_hex   <= upd.hex;
            lat_dp    <= upd.dp;
            lat_blank <= upd.blank;
            lat_ovf   <= !upd.hex && (upd.value > 16'd9999);
            ready_q   <= 1'b0;
            if (conv_start) begin
              state <= ST_CONV;
              busy  <= 1'b1;
              ovf   <= 1'b0;
            end else begin
              state <= ST_COMMIT;
              if (!upd.hex) ovf <= 1'b1;
            end
          end
        end
        ST_CONV: begin
          if (conv_done) begin
            busy  <= 1'b0;
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          sh_seg   <= commit_seg;
          sh_dp    <= lat_dp;
          sh_blank <= lat_ovf ? 4'd0 : lat_blank;
          ready_q  <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [CW-1:0] pre;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic          tick;
  logic [3:0]    onehot;
  logic [6:0]    seg_raw;
  logic          dp_raw;

  assign tick    = enable && (pre == CW'(DIV - 1));
  assign idx_nxt = !enable ? 2'd0 : (tick ? idx + 2'd1 : idx);

  always_comb begin
    onehot  = 4'b0001 << idx_nxt;
    seg_raw = sh_blank[idx_nxt] ? SEG_OFF : sh_seg[idx_nxt];
    dp_raw  = !sh_blank[idx_nxt] && sh_dp[idx_nxt];
  end

  // Output registers load from idx_nxt so the pins follow the index on the cycle after tick.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      pre <= '0;
      idx <= 2'd0;
      com <= COM_OFF;
      seg <= SEG_OUT_OFF;
      dp  <= DP_OFF;
    end else begin
      if (!enable || tick) pre <= '0;
      else                 pre <= pre + CW'(1);
      idx <= idx_nxt;
      if (!enable) begin
        com <= COM_OFF;
        seg <= SEG_OUT_OFF;
        dp  <= DP_OFF;
      end else begin
        com <= COM_ACT_L ? ~onehot : onehot;
        seg <= SEG_ACT_L ? ~seg_raw : seg_raw;
        dp  <= SEG_ACT_L ? ~dp_raw : dp_raw;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - scoreboard bench for fnd_scan_ctrl with DIV=4 and active-low outputs
module tb_fnd_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       busy;
  logic       ovf;
  logic [3:0] com;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int failures = 0;

  fnd_scan_ctrl_if upd();

  fnd_scan_ctrl #(
    .CLK_HZ    (8),
    .SCAN_HZ   (2),
    .COM_ACT_L (1'b1),
    .SEG_ACT_L (1'b1)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .enable          (enable),
    .upd             (upd),
    .busy            (busy),
    .ovf             (ovf),
    .com             (com),
    .seg             (seg),
    .dp              (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] com;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[n];
  endfunction

  task automatic push_digits(input logic [15:0] nib, input logic [3:0] dpm,
                             input logic [3:0] blank, input bit dash);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.com = ~(4'b0001 << i);
      if (blank[i] && !dash) begin
        e.seg = 7'h7F;
        e.dp  = 1'b1;
      end else begin
        e.seg = ~(dash ? 7'h40 : ref_seg(nib[4*i +: 4]));
        e.dp  = ~dpm[i];
      end
      sb.push_back(e);
    end
  endtask

  task automatic scan_check(input string tag);
    exp_t e;
    bit   found;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      found = 0;
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        if (com === e.com) begin
          found = 1;
          break;
        end
      end
      if (!found) begin
        check({tag, "_com_timeout"}, com, e.com);
      end else begin
        check({tag, "_seg"}, seg, e.seg);
        check({tag, "_dp"}, dp, e.dp);
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int c = 0; c < 64; c++) begin
      if (upd.ready) break;
      @(negedge clk);
    end
    check({tag, "_ready"}, upd.ready, 1);
  endtask

  // Returns at the negedge of the first cycle after the accepting edge.
  task automatic send(input logic [15:0] v, input bit hx, input logic [3:0] dpm, input logic [3:0] blank);
    wait_ready("send");
    upd.value = v;
    upd.hex   = hx;
    upd.dp    = dpm;
    upd.blank = blank;
    upd.valid = 1'b1;
    @(negedge clk);
    upd.valid = 1'b0;
  endtask

  int n;
  int rb;

  initial begin
    upd.valid = 1'b0;
    upd.value = 16'd0;
    upd.hex   = 1'b0;
    upd.dp    = 4'd0;
    upd.blank = 4'd0;
    enable    = 1'b1;

    // 1 reset state, then a fully blank scan
    repeat (3) @(negedge clk);
    check("rst_com", com, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_ready", upd.ready, 1);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    push_digits(16'h0000, 4'h0, 4'hF, 0);
    scan_check("rst_blank");

    // 2 hex update with accept-to-ready timing and scan period
    send(16'h1A3F, 1'b1, 4'b0100, 4'b0000);
    check("hex_ready_c1", upd.ready, 0);
    @(negedge clk);
    check("hex_ready_c2", upd.ready, 1);
    repeat (2) @(negedge clk);
    push_digits(16'h1A3F, 4'b0100, 4'b0000, 0);
    scan_check("hex");
    for (int c = 0; c < 64 && com !== 4'b1110; c++) @(negedge clk);
    for (int c = 0; c < 16 && com === 4'b1110; c++) @(negedge clk);
    n = 0;
    for (int c = 0; c < 16 && com === 4'b1101; c++) begin
      n++;
      @(negedge clk);
    end
    check("scan_period", n, 4);

    // 3 decimal update, with an ignored request while converting
    send(16'd1234, 1'b0, 4'b0000, 4'b0000);
    n = 0;
    rb = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      n++;
      if (upd.ready) rb++;
      if (n == 5) begin
        upd.valid = 1'b1;
        upd.value = 16'h7777;
        upd.hex   = 1'b1;
      end else begin
        upd.valid = 1'b0;
      end
      @(negedge clk);
    end
    upd.valid = 1'b0;
    check("dec_busy_cycles", n, 16);
    check("dec_ready_low", rb, 0);
    wait_ready("dec");
    check("dec_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    push_digits(16'h1234, 4'b0000, 4'b0000, 0);
    scan_check("dec");

    // 4 overflow shows dashes regardless of blank mask, then 9999 clears ovf
    send(16'd10000, 1'b0, 4'b0000, 4'hF);
    check("ovf_no_conv", busy, 0);
    wait_ready("ovf");
    check("ovf_set", ovf, 1);
    repeat (2) @(negedge clk);
    push_digits(16'h0000, 4'b0000, 4'hF, 1);
    scan_check("ovf");
    send(16'd9999, 1'b0, 4'b0000, 4'b0000);
    wait_ready("d9999");
    check("ovf_clr", ovf, 0);
    repeat (2) @(negedge clk);
    push_digits(16'h9999, 4'b0000, 4'b0000, 0);
    scan_check("d9999");

    // 5 enable low mid-scan, update still accepted, restart at digit 0
    for (int c = 0; c < 64 && com !== 4'b1011; c++) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_com", com, 4'hF);
    check("dis_seg", seg, 7'h7F);
    send(16'h00C0, 1'b1, 4'b0000, 4'b0000);
    wait_ready("dis_upd");
    repeat (3) @(negedge clk);
    check("dis_com_held", com, 4'hF);
    enable = 1'b1;
    for (int c = 0; c < 8 && com === 4'hF; c++) @(negedge clk);
    check("en_restart", com, 4'b1110);
    push_digits(16'h00C0, 4'b0000, 4'b0000, 0);
    scan_check("en");

    // 6 reset during conversion, then a normal hex update
    send(16'd4321, 1'b0, 4'b0000, 4'b0000);
    repeat (4) @(negedge clk);
    check("conv_busy_pre_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_com", com, 4'hF);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_dp", dp, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", upd.ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(16'h0005, 1'b1, 4'b0000, 4'b1110);
    wait_ready("post_rst");
    repeat (2) @(negedge clk);
    push_digits(16'h0005, 4'b0000, 4'b1110, 0);
    scan_check("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
